// File: rtl/sipo_pkg.sv
// sipo_pkg: shared definitions for the serial-to-parallel collector.
//   state_e        : collector FSM states (ST_IDLE, ST_COLLECT)
//   DEFAULT_WIDTH  : default data bits per frame
//   flen()         : serial bits per frame, including the optional parity bit
// Optional feature macro: SIPO_PARITY_EN (one trailing even-parity bit per frame).
package sipo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 32'd4;

    // Serial bits that make up one frame on the wire.
    function automatic int unsigned flen(input int unsigned width);
`ifdef SIPO_PARITY_EN
        return width + 32'd1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_collector_if.sv
// sipo_collector_if: serial input and parallel handshake bundle of sipo_collector.
//   sin, sin_valid, frame_start : qualified serial stream and frame marker
//   par_data, par_valid         : assembled frame and its valid flag
//   par_ready                   : consumer accept
//   overrun, overrun_clr        : sticky dropped-frame flag and its clear
//   parity_err                  : parity result of the held frame
// modport master = stream source / consumer side, modport slave = collector side.
interface sipo_collector_if import sipo_pkg::*; #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();
    logic             sin;
    logic             sin_valid;
    logic             frame_start;
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic             overrun;
    logic             overrun_clr;
    logic             parity_err;

    modport master (
        output sin, sin_valid, frame_start, par_ready, overrun_clr,
        input  par_data, par_valid, overrun, parity_err
    );

    modport slave (
        input  sin, sin_valid, frame_start, par_ready, overrun_clr,
        output par_data, par_valid, overrun, parity_err
    );
endinterface

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: W-bit serial-in shift register, new bits enter at bit 0.
//   clk, rst_n : clock, asynchronous active-low reset (clears contents)
//   en_i       : shift enable
//   sin_i      : serial input bit
//   data_o     : parallel contents
module sipo_shift_reg #(
    parameter int unsigned W = 32'd4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         sin_i,
    output logic [W-1:0] data_o
);
    logic [W-1:0] shreg_q;
    logic [W-1:0] shreg_d;

    // Next-state: shift one bit in when enabled, otherwise hold.
    always_comb begin
        shreg_d = shreg_q;
        if (en_i) begin
            shreg_d = {shreg_q[W-2:0], sin_i};
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign data_o = shreg_q;
endmodule

// File: rtl/sipo_collector.sv
// sipo_collector: samples a qualified serial stream, assembles WIDTH-bit frames
// MSB-first and holds each on a registered valid/ready parallel port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sipo_collector_if.slave (serial in, parallel out, overrun, parity_err)
// Optional feature macro: SIPO_PARITY_EN adds a trailing even-parity bit per frame
// and drives parity_err; without it parity_err is held at 0.
module sipo_collector import sipo_pkg::*; #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    sipo_collector_if.slave   bus
);
    localparam int unsigned FLEN  = flen(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 32'd2);

    // Even-parity check over the data bits and the received parity bit.
    function automatic logic parity_calc(input logic [FLEN-1:0] v);
        return ^v;
    endfunction

    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [WIDTH-1:0]   par_data_q,   par_data_d;
    logic               par_valid_q,  par_valid_d;
    logic               overrun_q,    overrun_d;
    logic               parity_err_q, parity_err_d;

    logic               shift_en_s;
    logic               complete_s;
    logic [FLEN-1:0]    shreg_s;
    logic [FLEN-1:0]    full_s;
    logic [WIDTH-1:0]   frame_data_s;
    logic               frame_perr_s;

    // Bits are only taken while collecting, or when they open a new frame.
    assign shift_en_s = bus.sin_valid && ((state_q == ST_COLLECT) || bus.frame_start);

    sipo_shift_reg #(.W(FLEN)) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (shift_en_s),
        .sin_i  (bus.sin),
        .data_o (shreg_s)
    );

    // The completing bit is still on sin, so the frame is the shift result of this edge.
    assign full_s = {shreg_s[FLEN-2:0], bus.sin};

`ifdef SIPO_PARITY_EN
    assign frame_data_s = full_s[WIDTH:1];
    assign frame_perr_s = parity_calc(full_s);
`else
    assign frame_data_s = full_s[WIDTH-1:0];
    assign frame_perr_s = 1'b0;
`endif

    // FSM next state and bit counter; flags the edge on which a frame completes.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        complete_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.sin_valid && bus.frame_start) begin
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_COLLECT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (bus.sin_valid && bus.frame_start) begin
                    // Restart: partial frame dropped silently, this bit is bit 1.
                    bit_cnt_d = CNT_W'(1);
                end else if (bus.sin_valid) begin
                    if ((bit_cnt_q + CNT_W'(1)) == CNT_W'(FLEN)) begin
                        complete_s = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Output register, handshake and sticky overrun (a set beats a same-edge clear).
    always_comb begin
        par_data_d   = par_data_q;
        par_valid_d  = par_valid_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (complete_s) begin
            if (!par_valid_q || bus.par_ready) begin
                par_data_d   = frame_data_s;
                par_valid_d  = 1'b1;
                parity_err_d = frame_perr_s;
            end else begin
                overrun_d    = 1'b1;
            end
        end else if (par_valid_q && bus.par_ready) begin
            par_valid_d = 1'b0;
        end else begin
            par_valid_d = par_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            par_data_q   <= '0;
            par_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            par_data_q   <= par_data_d;
            par_valid_q  <= par_valid_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.par_data   = par_data_q;
    assign bus.par_valid  = par_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.parity_err = parity_err_q;
endmodule
